riscv_imem_responder: RTL

// - Instruction-memory responder that services fetches from riscv_processor.
// - The processor core is the initiator: it presents its PC and consumes the returned instruction word.
// - The responder owns the instruction store, which a loader port fills before or between fetches.
// - Used in both simulation and synthesis, replacing the ad-hoc testbench instruction array.

---
 rtl/riscv_imem_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/riscv_imem_responder.sv
// Instruction-memory responder for riscv_processor: loader-filled word store,
// one fetch in flight, fixed response latency, response held until acknowledged.
module riscv_imem_responder #(
  parameter  int DEPTH   = 64,
  parameter  int LATENCY = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load_en,
  input  logic [AW-1:0] i_load_addr,
  input  logic [31:0]   i_load_data,
  input  logic          i_fetch_req,
  input  logic [31:0]   i_fetch_pc,
  output logic          o_fetch_ready,
  output logic          o_instr_valid,
  output logic [31:0]   o_instr_out,
  output logic          o_instr_err,
  input  logic          i_instr_ack
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [31:0]      r_pend_data;
  logic             r_pend_err;
  logic [31:0]      r_mem [DEPTH];
  logic [DEPTH-1:0] r_loaded;

  logic [AW-1:0]    w_idx;
  logic             w_err;
  logic             w_accept;
  logic [31:0]      w_rdata;

  assign w_idx    = i_fetch_pc[AW+1:2];
  assign w_err    = (i_fetch_pc[1:0] != 2'b00) || (i_fetch_pc[31:AW+2] != '0);
  assign w_accept = (r_state == S_IDLE) && i_fetch_req;

  // Write-first: a load landing on the fetched word this cycle wins over the array.
  always_comb begin
    w_rdata = NOP;
    if (!w_err) begin
      if (i_load_en && (i_load_addr == w_idx))
        w_rdata = i_load_data;
      else if (r_loaded[w_idx])
        w_rdata = r_mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (i_load_en)
      r_mem[i_load_addr] <= i_load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_loaded <= '0;
    else if (i_load_en)
      r_loaded[i_load_addr] <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_pend_data   <= NOP;
      r_pend_err    <= 1'b0;
      o_fetch_ready <= 1'b1;
      o_instr_valid <= 1'b0;
      o_instr_out   <= NOP;
      o_instr_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            o_fetch_ready <= 1'b0;
            r_pend_data   <= w_rdata;
            r_pend_err    <= w_err;
            if (LATENCY == 1) begin
              r_state       <= S_RESP;
              o_instr_valid <= 1'b1;
              o_instr_out   <= w_rdata;
              o_instr_err   <= w_err;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state       <= S_RESP;
            o_instr_valid <= 1'b1;
            o_instr_out   <= r_pend_data;
            o_instr_err   <= r_pend_err;
          end
          r_cnt <= r_cnt - 4'd1;
        end
        S_RESP: begin
          if (i_instr_ack) begin
            r_state       <= S_IDLE;
            o_instr_valid <= 1'b0;
            o_fetch_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          o_fetch_ready <= 1'b1;
          o_instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
